// File: rtl/mc_pkg.sv
// mc_pkg: opcodes, functs, ALU codes, FSM states and decode helpers for the multi-cycle core
package mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;
  function automatic logic [3:0] funct_alu(input logic [5:0] f);
    return f == FN_SUB ? ALU_SUB : f == FN_AND ? ALU_AND : f == FN_OR ? ALU_OR : f == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] f);
    return op == OP_RTYPE ? f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT} : op inside {OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction
endpackage

// File: rtl/mc_processor_if.sv
// mc_processor_if: instruction/data memory handshakes and status of the multi-cycle core
interface mc_processor_if;
  logic [31:0] inst_addr, instr, data_addr, data_in, data_out;
  logic inst_req, inst_ready, mem_read, mem_write, mem_ready, retire, halted;
  modport master(output inst_addr, inst_req, data_addr, data_in, mem_read, mem_write, retire, halted,
                 input instr, inst_ready, data_out, mem_ready);
  modport slave(input inst_addr, inst_req, data_addr, data_in, mem_read, mem_write, retire, halted,
                output instr, inst_ready, data_out, mem_ready);
endinterface

// File: rtl/alu.sv
// alu: 32-bit add/sub/and/or/signed-slt selected by a 4-bit operation code
module alu
  import mc_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  always_comb
    y_o = op_i == ALU_SUB ? a_i - b_i :
          op_i == ALU_AND ? a_i & b_i :
          op_i == ALU_OR  ? a_i | b_i :
          op_i == ALU_SLT ? {31'd0, $signed(a_i) < $signed(b_i)} : a_i + b_i;
endmodule

// File: rtl/mc_control.sv
// mc_control: FSM and instruction decode driving the multi-cycle datapath
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       inst_ready_i,
  input  logic       mem_ready_i,
  input  logic       eq_i,
  output state_e     state_o,
  output logic [3:0] alu_op_o,
  output logic       reg_we_o,
  output logic       wr_rd_o,
  output logic       wd_mdr_o,
  output logic       pc_inc_o,
  output logic       pc_br_o,
  output logic       pc_jmp_o,
  output logic       inst_req_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       retire_o,
  output logic       halted_o
);
  state_e state_q, state_d;
  logic boot_q, rtype, mem_op, ctl_op;
  // boot_q keeps fetch quiet for the cycle in which reset is released
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= FETCH;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b0;
    end
  always_comb begin
    rtype       = op_i == OP_RTYPE;
    mem_op      = op_i == OP_LW || op_i == OP_SW;
    ctl_op      = op_i == OP_BEQ || op_i == OP_J;
    inst_req_o  = state_q == FETCH && !boot_q;
    pc_inc_o    = inst_req_o && inst_ready_i;
    alu_op_o    = state_q == EXEC && rtype ? funct_alu(funct_i) : ALU_ADD;
    pc_br_o     = state_q == EXEC && op_i == OP_BEQ && eq_i;
    pc_jmp_o    = state_q == EXEC && op_i == OP_J;
    mem_read_o  = state_q == MEM && op_i == OP_LW;
    mem_write_o = state_q == MEM && op_i == OP_SW;
    reg_we_o    = state_q == WB;
    retire_o    = reg_we_o || (state_q == EXEC && ctl_op) || (mem_write_o && mem_ready_i);
    halted_o    = state_q == HALT;
    wr_rd_o     = rtype;
    wd_mdr_o    = op_i == OP_LW;
    state_o     = state_q;
    case (state_q)
      FETCH:   state_d = pc_inc_o ? DECODE : FETCH;
      DECODE:  state_d = is_legal(op_i, funct_i) ? EXEC : HALT;
      EXEC:    state_d = ctl_op ? FETCH : mem_op ? MEM : WB;
      MEM:     state_d = !mem_ready_i ? MEM : mem_write_o ? FETCH : WB;
      WB:      state_d = FETCH;
      default: state_d = HALT;
    endcase
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 GPRs, two read ports, one write port, R0 hard-wired to zero
module reg_file #(
  parameter bit ZERO_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  input  logic        we_i,
  output logic [31:0] rda_o,
  output logic [31:0] rdb_o
);
  logic [31:0] r_q [32];
  always_ff @(posedge clk)
    if (reset && ZERO_ON_RESET) for (int i = 0; i < 32; i++) r_q[i] <= '0;
    else if (we_i && wa_i != 5'd0) r_q[wa_i] <= wd_i;
  always_comb begin
    rda_o = ra_i == 5'd0 ? '0 : r_q[ra_i];
    rdb_o = rb_i == 5'd0 ? '0 : r_q[rb_i];
  end
endmodule

// File: rtl/mc_processor.sv
// mc_processor: multi-cycle MIPS-subset core; one shared ALU pass per FSM state
module mc_processor
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR         = 32'h0000_0000,
  parameter bit          ZERO_REGS_ON_RESET = 1'b1
) (
  input logic            clk,
  input logic            reset,
  mc_processor_if.master bus
);
  state_e      state;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q, tgt_q;
  logic [31:0] sext, alu_a, alu_b, alu_y, rs_data, rt_data;
  logic [3:0]  alu_op;
  logic        reg_we, wr_rd, wd_mdr, pc_inc, pc_br, pc_jmp;
  mc_control u_ctl (
    .clk(clk), .reset(reset), .op_i(ir_q[31:26]), .funct_i(ir_q[5:0]),
    .inst_ready_i(bus.inst_ready), .mem_ready_i(bus.mem_ready), .eq_i(a_q == b_q),
    .state_o(state), .alu_op_o(alu_op), .reg_we_o(reg_we), .wr_rd_o(wr_rd), .wd_mdr_o(wd_mdr),
    .pc_inc_o(pc_inc), .pc_br_o(pc_br), .pc_jmp_o(pc_jmp), .inst_req_o(bus.inst_req),
    .mem_read_o(bus.mem_read), .mem_write_o(bus.mem_write), .retire_o(bus.retire), .halted_o(bus.halted)
  );
  // FETCH computes PC+4, DECODE the branch target, EXEC the instruction result
  always_comb begin
    sext  = {{16{ir_q[15]}}, ir_q[15:0]};
    alu_a = state == FETCH || state == DECODE ? pc_q : a_q;
    alu_b = state == FETCH ? 32'd4 : state == DECODE ? {sext[29:0], 2'b00} : ir_q[31:26] == OP_RTYPE ? b_q : sext;
  end
  alu u_alu (.op_i(alu_op), .a_i(alu_a), .b_i(alu_b), .y_o(alu_y));
  reg_file #(.ZERO_ON_RESET(ZERO_REGS_ON_RESET)) u_rf (
    .clk(clk), .reset(reset), .ra_i(ir_q[25:21]), .rb_i(ir_q[20:16]),
    .wa_i(wr_rd ? ir_q[15:11] : ir_q[20:16]), .wd_i(wd_mdr ? mdr_q : alu_q),
    .we_i(reg_we && !reset), .rda_o(rs_data), .rdb_o(rt_data)
  );
  always_ff @(posedge clk)
    if (reset) begin
      pc_q  <= RESET_ADDR;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      tgt_q <= '0;
    end else begin
      if (pc_inc) begin
        pc_q <= alu_y;
        ir_q <= bus.instr;
      end
      if (pc_br) pc_q <= tgt_q;
      if (pc_jmp) pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
      if (state == DECODE) begin
        a_q   <= rs_data;
        b_q   <= rt_data;
        tgt_q <= alu_y;
      end
      if (state == EXEC) alu_q <= alu_y;
      if (bus.mem_read && bus.mem_ready) mdr_q <= bus.data_out;
    end
  always_comb begin
    bus.inst_addr = pc_q;
    bus.data_addr = alu_q;
    bus.data_in   = b_q;
  end
endmodule

// File: tb/tb_mc_processor.sv
// tb_mc_processor: directed programs with hand-computed bus activity for the multi-cycle core
module tb_mc_processor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem [1024];
  int          n_cmp = 0;
  int          n_bad = 0;
  mc_processor_if bus();
  mc_processor #(.RESET_ADDR(32'h100), .ZERO_REGS_ON_RESET(1'b0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.instr = imem[bus.inst_addr[11:2]];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bus.inst_ready = 1'b1;
    bus.mem_ready  = 1'b1;
    bus.data_out   = '0;
    for (int i = 0; i < 1024; i++) imem[i] = '0;
    imem[64]  = 32'h2001_0005;
    imem[65]  = 32'h2002_FFFD;
    imem[66]  = 32'h0022_1820;
    imem[67]  = 32'h0041_202A;
    imem[68]  = 32'hAC03_0008;
    imem[69]  = 32'hAC04_000C;
    imem[70]  = 32'h8C05_0008;
    imem[71]  = 32'hAC05_0010;
    imem[72]  = 32'h0800_0080;
    imem[128] = 32'h1021_FFFF;
    step(2);
    chk("rst_req", 32'(bus.inst_req), 32'd0);
    chk("rst_addr", bus.inst_addr, 32'h100);
    chk("rst_daddr", bus.data_addr, 32'd0);
    chk("rst_din", bus.data_in, 32'd0);
    chk("rst_rw", 32'({bus.mem_read, bus.mem_write, bus.retire, bus.halted}), 32'd0);
    reset = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      step(1);
      if (c == 1) chk("first_fetch", 32'({bus.inst_req, bus.inst_addr}), {1'b1, 32'h100});
      if (c == 5) chk("second_fetch", bus.inst_addr, 32'h104);
      chk($sformatf("retire_c%0d", c), 32'(bus.retire), 32'(c % 4 == 0));
    end
    bus.mem_ready = 1'b0;
    step(4);
    for (int k = 0; k < 3; k++) begin
      chk("sw_stall", {bus.data_addr[7:0], bus.data_in[7:0], 7'd0, bus.mem_write, 7'd0, bus.retire}, 32'h0802_0100);
      step(1);
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("sw_done", {bus.data_addr[7:0], bus.data_in[7:0], 7'd0, bus.mem_write, 7'd0, bus.retire}, 32'h0802_0101);
    step(1);
    chk("fetch_114", 32'({bus.inst_req, bus.mem_write, bus.inst_addr}), {2'b10, 32'h114});
    step(3);
    chk("slt_store", bus.data_in, 32'd1);
    chk("slt_addr", bus.data_addr, 32'd12);
    chk("sw_nowait", 32'({bus.mem_write, bus.retire}), 32'd3);
    bus.data_out = 32'd2;
    step(4);
    chk("lw_req", 32'({bus.mem_read, bus.data_addr}), {1'b1, 32'd8});
    step(1);
    chk("lw_wb", 32'({bus.mem_read, bus.retire}), 32'd1);
    step(4);
    chk("lw_store", bus.data_in, 32'd2);
    chk("lw_store_addr", bus.data_addr, 32'd16);
    step(4);
    chk("j_200", bus.inst_addr, 32'h200);
    step(2);
    chk("beq_retire", 32'(bus.retire), 32'd1);
    step(1);
    chk("beq_loop1", 32'({bus.inst_req, bus.inst_addr}), {1'b1, 32'h200});
    step(3);
    chk("beq_loop2", 32'({bus.inst_req, bus.inst_addr}), {1'b1, 32'h200});
    imem[128] = 32'h0800_0040;
    imem[64]  = 32'hFC00_0000;
    step(2);
    chk("j_retire", 32'(bus.retire), 32'd1);
    step(1);
    chk("j_100", bus.inst_addr, 32'h100);
    step(1);
    chk("ill_dec", 32'({bus.halted, bus.retire}), 32'd0);
    step(1);
    for (int k = 0; k < 20; k++) begin
      chk("halt_quiet", 32'({bus.halted, bus.inst_req, bus.mem_read, bus.mem_write, bus.retire}), 32'b10000);
      step(1);
    end
    chk("halt_pc", bus.inst_addr, 32'h104);
    reset = 1'b1;
    step(1);
    chk("rst_unhalt", 32'({bus.halted, bus.inst_req}), 32'd0);
    chk("rst_pc", bus.inst_addr, 32'h100);
    imem[64] = 32'h0000_0000;
    reset = 1'b0;
    step(1);
    chk("rfn_fetch", 32'({bus.inst_req, bus.inst_addr}), {1'b1, 32'h100});
    step(2);
    chk("rfn_halt", 32'({bus.halted, bus.retire, bus.inst_req}), 32'b100);
    chk("rfn_pc", bus.inst_addr, 32'h104);
    reset = 1'b1;
    imem[64] = 32'h2001_0007;
    imem[65] = 32'h8C01_0008;
    bus.mem_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(8);
    chk("lw_stall", 32'({bus.mem_read, bus.data_addr}), {1'b1, 32'd8});
    step(1);
    chk("lw_stall2", 32'(bus.mem_read), 32'd1);
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.data_out = 32'hDEAD_BEEF;
    step(1);
    chk("abort_rd", 32'({bus.mem_read, bus.inst_req}), 32'd0);
    chk("abort_pc", bus.inst_addr, 32'h100);
    chk("abort_daddr", bus.data_addr, 32'd0);
    imem[64] = 32'hAC01_0014;
    bus.inst_ready = 1'b0;
    reset = 1'b0;
    step(1);
    chk("ifetch_wait1", 32'(bus.inst_req), 32'd1);
    step(1);
    chk("ifetch_wait2", 32'({bus.inst_req, bus.inst_addr}), {1'b1, 32'h100});
    bus.inst_ready = 1'b1;
    step(3);
    chk("r1_kept", bus.data_in, 32'd7);
    chk("r1_addr", bus.data_addr, 32'd20);
    chk("r1_sw", 32'({bus.mem_write, bus.retire}), 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
